// File: rtl/layer_line_scheduler_if.sv
// Handshake bundle between video timing, the layer renderer, the composer and
// the layer line scheduler.
interface layer_line_scheduler_if #(
    parameter int IDX_WIDTH = 10
);
    logic                 line_start;
    logic                 render_done;
    logic                 render_start;
    logic                 render_abort;
    logic                 active_render_buffer;
    logic                 composer_pixel_en;
    logic [7:0]           hscale;
    logic [IDX_WIDTH-1:0] composer_rd_idx;
    logic                 underrun;
    logic                 underrun_clr;
    logic [7:0]           underrun_count;

    // Master drives timing/renderer/composer requests; slave is the scheduler.
    modport master (
        output line_start, render_done, composer_pixel_en, hscale, underrun_clr,
        input  render_start, render_abort, active_render_buffer,
               composer_rd_idx, underrun, underrun_count
    );

    modport slave (
        input  line_start, render_done, composer_pixel_en, hscale, underrun_clr,
        output render_start, render_abort, active_render_buffer,
               composer_rd_idx, underrun, underrun_count
    );
endinterface

// File: rtl/layer_line_scheduler.sv
// Double-buffered layer line sequencing, fractional read-index generation and
// renderer underrun detection. Define LINE_SCHED_STATS_EN to keep underrun_count.
module layer_line_scheduler #(
    parameter int IDX_WIDTH  = 10,
    parameter int FRAC_WIDTH = 7
) (
    input logic                    clk,
    input logic                    rst,
    layer_line_scheduler_if.slave  bus
);
    localparam int ACC_W = IDX_WIDTH + FRAC_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RENDER,
        ST_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic             underrun_ev;
    logic             render_start_q;
    logic             render_abort_q;
    logic             active_buf_q;
    logic             underrun_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       underrun_count_q;

    // Unsigned add that pins at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_acc_add(input logic [ACC_W-1:0] a,
                                                      input logic [7:0]       b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        underrun_ev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.line_start) state_nxt = ST_RENDER;
            end
            ST_RENDER: begin
                // A done coinciding with the line start still counts as on time.
                if (bus.line_start) begin
                    state_nxt   = ST_RENDER;
                    underrun_ev = !bus.render_done;
                end else if (bus.render_done) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.line_start) state_nxt = ST_RENDER;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            render_start_q <= 1'b0;
            render_abort_q <= 1'b0;
            active_buf_q   <= 1'b0;
            underrun_q     <= 1'b0;
            acc_q          <= '0;
        end else begin
            render_start_q <= bus.line_start;
            render_abort_q <= underrun_ev;
            if (bus.line_start) begin
                active_buf_q <= ~active_buf_q;
            end
            // A new underrun wins over a simultaneous clear.
            if (underrun_ev) begin
                underrun_q <= 1'b1;
            end else if (bus.underrun_clr) begin
                underrun_q <= 1'b0;
            end
            if (bus.line_start) begin
                acc_q <= '0;
            end else if (bus.composer_pixel_en) begin
                acc_q <= sat_acc_add(acc_q, bus.hscale);
            end
        end
    end

`ifdef LINE_SCHED_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_count_q <= '0;
        end else if (underrun_ev) begin
            underrun_count_q <= sat_inc8(underrun_count_q);
        end
    end
`else
    assign underrun_count_q = '0;
`endif

    assign bus.render_start         = render_start_q;
    assign bus.render_abort         = render_abort_q;
    assign bus.active_render_buffer = active_buf_q;
    assign bus.composer_rd_idx      = acc_q[ACC_W-1:FRAC_WIDTH];
    assign bus.underrun             = underrun_q;
    assign bus.underrun_count       = underrun_count_q;
endmodule

// File: tb/tb_layer_line_scheduler.sv
// Randomized and directed bench for layer_line_scheduler against a
// line-level reference model.
module tb_layer_line_scheduler;
    localparam int IDX_WIDTH  = 10;
    localparam int FRAC_WIDTH = 7;
    localparam int ACC_MAX    = (1 << (IDX_WIDTH + FRAC_WIDTH)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: line-level view of the scheduler.
    bit m_in_flight;
    bit m_start, m_abort, m_buf, m_under;
    int m_count;
    int m_acc;

    layer_line_scheduler_if #(.IDX_WIDTH(IDX_WIDTH)) bus ();

    layer_line_scheduler #(
        .IDX_WIDTH  (IDX_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("render_start", 32'(bus.render_start), 32'(m_start));
        check_eq("render_abort", 32'(bus.render_abort), 32'(m_abort));
        check_eq("active_buf",   32'(bus.active_render_buffer), 32'(m_buf));
        check_eq("rd_idx",       32'(bus.composer_rd_idx), 32'(m_acc >> FRAC_WIDTH));
        check_eq("underrun",     32'(bus.underrun), 32'(m_under));
        check_eq("underrun_cnt", 32'(bus.underrun_count), 32'(m_count));
    endtask

    // Apply one cycle of inputs, advance the model and compare every output.
    task automatic step(input bit r, input bit ls, input bit rd, input bit en,
                        input int hs, input bit clr);
        bit ev;
        rst                   = r;
        bus.line_start        = ls;
        bus.render_done       = rd;
        bus.composer_pixel_en = en;
        bus.hscale            = 8'(hs);
        bus.underrun_clr      = clr;
        @(posedge clk);
        if (!r) begin
            m_in_flight = 0; m_start = 0; m_abort = 0; m_buf = 0;
            m_under = 0; m_count = 0; m_acc = 0;
        end else begin
            ev = ls && m_in_flight && !rd;
            m_start = ls;
            m_abort = ev;
            if (ls) m_buf = !m_buf;
            if (ev) m_under = 1;
            else if (clr) m_under = 0;
`ifdef LINE_SCHED_STATS_EN
            if (ev && m_count < 255) m_count++;
`endif
            if (ls) m_in_flight = 1;
            else if (rd) m_in_flight = 0;
            if (ls) m_acc = 0;
            else if (en) m_acc = (m_acc + hs > ACC_MAX) ? ACC_MAX : m_acc + hs;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit en, input int hs);
        for (int i = 0; i < n; i++) step(1, 0, 0, en, hs, 0);
    endtask

    initial begin
        bus.line_start = 0; bus.render_done = 0; bus.composer_pixel_en = 0;
        bus.hscale = 8'd128; bus.underrun_clr = 0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 128, 0);
        idle(7, 0, 128);

        // First line from idle, renderer finishes in time, next line swaps back.
        step(1, 1, 0, 0, 128, 0);
        check_eq("first_buf", 32'(bus.active_render_buffer), 32'd1);
        check_eq("first_start", 32'(bus.render_start), 32'd1);
        idle(1, 0, 128);
        check_eq("start_one_cycle", 32'(bus.render_start), 32'd0);
        idle(288, 0, 128);
        step(1, 0, 1, 0, 128, 0);
        idle(499, 0, 128);
        step(1, 1, 0, 0, 128, 0);
        check_eq("swap_back_buf", 32'(bus.active_render_buffer), 32'd0);
        check_eq("ontime_underrun", 32'(bus.underrun), 32'd0);

        // Underrun, then clear.
        idle(40, 0, 128);
        step(1, 1, 0, 0, 128, 0);
        check_eq("ur_abort", 32'(bus.render_abort), 32'd1);
        check_eq("ur_flag", 32'(bus.underrun), 32'd1);
        idle(3, 0, 128);
        step(1, 0, 0, 0, 128, 1);
        check_eq("ur_cleared", 32'(bus.underrun), 32'd0);

        // Coincident done and line start.
        idle(20, 0, 128);
        step(1, 1, 1, 0, 128, 0);
        check_eq("coinc_abort", 32'(bus.render_abort), 32'd0);
        check_eq("coinc_start", 32'(bus.render_start), 32'd1);

        // Line start while a new underrun and a clear coincide: set wins.
        idle(5, 0, 128);
        step(1, 1, 0, 0, 128, 1);
        check_eq("set_wins", 32'(bus.underrun), 32'd1);

        // Scaling.
        step(1, 0, 1, 0, 64, 1);
        step(1, 1, 0, 0, 64, 0);
        idle(10, 1, 64);
        check_eq("hs64_idx", 32'(bus.composer_rd_idx), 32'd5);
        step(1, 1, 1, 1, 128, 0);
        check_eq("ls_priority", 32'(bus.composer_rd_idx), 32'd0);
        idle(10, 1, 128);
        check_eq("hs128_idx", 32'(bus.composer_rd_idx), 32'd10);
        idle(5, 1, 0);
        check_eq("hs0_hold", 32'(bus.composer_rd_idx), 32'd10);
        step(1, 1, 1, 0, 255, 0);
        idle(600, 1, 255);
        check_eq("hs255_sat", 32'(bus.composer_rd_idx), 32'd1023);

        // Back-to-back starts: counter saturation.
        for (int i = 0; i < 262; i++) step(1, 1, 0, 0, 128, 0);
`ifdef LINE_SCHED_STATS_EN
        check_eq("count_sat", 32'(bus.underrun_count), 32'd255);
`else
        check_eq("count_off", 32'(bus.underrun_count), 32'd0);
`endif
        check_eq("sat_flag", 32'(bus.underrun), 32'd1);

        // Mid-line reset: everything cleared, no abort.
        step(0, 0, 0, 0, 128, 0);
        check_eq("rst_abort", 32'(bus.render_abort), 32'd0);
        step(1, 1, 0, 0, 128, 0);
        check_eq("idle_no_ur", 32'(bus.underrun), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, ls, rd, en, clr;
            int hs;
            r   = ($urandom_range(0, 999) != 0);
            ls  = ($urandom_range(0, 39) == 0);
            rd  = ($urandom_range(0, 29) == 0);
            en  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       hs = 0;
                1:       hs = 255;
                default: hs = int'($urandom_range(0, 255));
            endcase
            step(r, ls, rd, en, hs, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
